// File: rtl/dmac_pkg.sv
// Shared types and AXI constants for the DMAC write engine.
// burst_beats() sizes one INCR burst from the words still to send.
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B       = 3'b010;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam int         MAX_BEATS_DEF = 16;

    function automatic logic [13:0] burst_beats(input logic [13:0] remaining,
                                                input logic [13:0] max_beats);
        return (remaining < max_beats) ? remaining : max_beats;
    endfunction

endpackage

// File: rtl/dmac_wr_engine.sv
// DMAC write engine: drains the DMAC FIFO into AXI INCR write bursts, one burst
// outstanding at a time, with a sticky error flag for non-OKAY write responses.
//
// state   | meaning
// IDLE    | waiting for start_i
// AW      | presenting the burst address, waiting for awready_i
// W       | streaming FIFO words, one pop per W handshake
// B       | waiting for the write response of the current burst
// DONE    | one-cycle completion pulse
module dmac_wr_engine
    import dmac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = MAX_BEATS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [31:0]             dst_addr_i,
    input  logic [15:0]             byte_len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    fifo_empty_i,
    output logic                    fifo_rden_o,
    input  logic [DATA_WIDTH-1:0]   fifo_rdata_i,
    output logic [31:0]             awaddr_o,
    output logic [3:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
);

    localparam logic [13:0] MAX_BEATS_W = 14'(MAX_BEATS);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [13:0] rem_q;
    logic [13:0] beats_q;
    logic [13:0] beat_cnt_q;
    logic        err_q;

    logic [13:0] len_words;
    logic [13:0] rem_d;
    logic        last_beat;
    logic        w_hs;
    logic        unused_len_bits;

    // Only whole words are moved; the byte remainder of the length is dropped.
    assign len_words       = byte_len_i[15:2];
    assign unused_len_bits = ^byte_len_i[1:0];
    assign rem_d           = rem_q - beats_q;
    assign last_beat       = (beat_cnt_q == beats_q - 14'd1);
    assign w_hs            = wvalid_o & wready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q     <= dst_addr_i;
                        rem_q      <= len_words;
                        beats_q    <= burst_beats(len_words, MAX_BEATS_W);
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                        state_q    <= (len_words == '0) ? ST_DONE : ST_AW;
                    end
                end
                ST_AW: begin
                    if (awready_i) state_q <= ST_W;
                end
                ST_W: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            beat_cnt_q <= '0;
                            state_q    <= ST_B;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 14'd1;
                        end
                    end
                end
                ST_B: begin
                    if (bvalid_i) begin
                        if (bresp_i != RESP_OKAY) err_q <= 1'b1;
                        rem_q   <= rem_d;
                        addr_q  <= addr_q + {16'b0, beats_q, 2'b00};
                        beats_q <= burst_beats(rem_d, MAX_BEATS_W);
                        state_q <= (rem_d != '0) ? ST_AW : ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;

    assign awvalid_o   = (state_q == ST_AW);
    assign awaddr_o    = addr_q;
    assign awlen_o     = 4'(beats_q - 14'd1);
    assign awsize_o    = SIZE_4B;
    assign awburst_o   = BURST_INCR;

    // W channel is a zero-latency pass-through of the FIFO head.
    assign wvalid_o    = (state_q == ST_W) & ~fifo_empty_i;
    assign wdata_o     = fifo_rdata_i;
    assign wstrb_o     = '1;
    assign wlast_o     = (state_q == ST_W) & last_beat;
    assign fifo_rden_o = w_hs;

    assign bready_o    = (state_q == ST_B);

endmodule

// File: doc/dmac_wr_engine.md
DMAC_WR_ENGINE -- requirements
Module: dmac_wr_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI W-data and FIFO read-data width (bits).
REQ-002 SHALL have parameter MAX_BEATS, default 16, meaning the maximum number of beats per AXI write burst.
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports start_i  in  1  one-cycle transfer request; dst_addr_i  in  32  destination byte address; byte_len_i  in  16  transfer length in bytes.
REQ-006 SHALL have ports busy_o  out  1  transfer in progress; done_o  out  1  one-cycle completion pulse; err_o  out  1  sticky write-response error.
REQ-007 SHALL have ports fifo_empty_i  in  1  upstream FIFO empty; fifo_rden_o  out  1  FIFO pop; fifo_rdata_i  in  DATA_WIDTH  FIFO head word (valid while not empty).
REQ-008 SHALL have ports awaddr_o  out  32; awlen_o  out  4  beats-1; awsize_o  out  3; awburst_o  out  2; awvalid_o  out  1; awready_i  in  1.
REQ-009 SHALL have ports wdata_o  out  DATA_WIDTH; wstrb_o  out  DATA_WIDTH/8; wlast_o  out  1; wvalid_o  out  1; wready_i  in  1.
REQ-010 SHALL have ports bresp_i  in  2; bvalid_i  in  1; bready_o  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, AW, W, B, DONE.
REQ-012 IDLE: start_i=1 SHALL latch dst_addr_i and byte_len_i>>2 as remaining beats, clear err_o, go to AW (DONE if byte_len_i=0).
REQ-013 start_i while not IDLE SHALL be ignored; byte_len_i[1:0] SHALL be ignored (whole words only).
REQ-014 Burst beats SHALL be min(remaining, MAX_BEATS); awlen_o=beats-1, awsize_o=3'b010, awburst_o=2'b01 (INCR), wstrb_o all ones.
REQ-015 AW: awvalid_o=1 with stable awaddr_o/awlen_o until awready_i; handshake cycle moves to W.
REQ-016 W: wvalid_o SHALL equal !fifo_empty_i; wdata_o SHALL equal fifo_rdata_i combinationally; fifo_rdata_o never popped when empty.
REQ-017 fifo_rden_o SHALL equal wvalid_o & wready_i (exactly one pop per W handshake, zero added latency).
REQ-018 wlast_o SHALL be 1 on the final beat of each burst only; handshake of last beat moves to B.
REQ-019 B: bready_o=1; on bvalid_i, bresp_i!=2'b00 SHALL set err_o; then remaining-=beats, address+=beats*4, go AW if remaining>0 else DONE.
REQ-020 Error SHALL NOT abort the transfer; err_o stays set until next accepted start_i.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE; busy_o=1 in all states except IDLE.
REQ-022 Only one outstanding burst at any time; AW of next burst SHALL NOT issue before B of current.
REQ-023 dst_addr_i SHALL be 64-byte aligned by caller; engine SHALL NOT split at 4 KB (alignment guarantees no crossing).
REQ-024 awvalid_o, wvalid_o, bready_o SHALL be 0 outside AW, W, B respectively.

Reset
REQ-025 rst_n=0 at any clock edge SHALL force IDLE, counters/address 0, all outputs 0 (busy_o, done_o, err_o, awvalid_o, wvalid_o, wlast_o, bready_o, fifo_rden_o), including mid-burst.
REQ-026 Data in the upstream FIFO SHALL NOT be touched by engine reset; FIFO is reset by its own rst_n.

Structure
REQ-027 Package dmac_pkg SHALL hold the FSM state enum, AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY) and MAX_BEATS default.
REQ-028 Single flat module; no sub-module; instantiated in the DMAC top directly downstream of the DMAC FIFO.

Verification
REQ-029 start, addr 0x1000, len 64, FIFO pre-filled 16 words, wready=1 -> one AW awlen=15, 16 W beats back-to-back, wlast on beat 16, done_o 1 cycle after B.
REQ-030 len 100 (25 beats) -> bursts at 0x1000 awlen=15 and 0x1040 awlen=8; second AW only after first B.
REQ-031 FIFO empty for 5 cycles mid-burst -> wvalid_o=0, fifo_rden_o=0 those cycles; data order preserved, no underflow.
REQ-032 wready_i toggled every other cycle -> pops only on handshake cycles; wdata_o held stable while wvalid_o & !wready_i.
REQ-033 bresp=2'b10 on first of two bursts -> err_o=1, second burst still issued, done_o pulses; next start clears err_o.
REQ-034 rst_n low 1 cycle during W beat 7 -> next cycle IDLE, all outputs 0; len 0 start -> done_o next cycle, no AW.
